// File: rtl/cfdf_rr_scheduler_pkg.sv
// cfdf_sched_pkg: shared state encoding and pointer-width helper for the
// CFDF round-robin firing scheduler.
package cfdf_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_INVOKE  = 3'd2,
    S_WAIT_FC = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } sched_state_e;

  // Actor pointer width: clog2 of the actor count, never narrower than 1 bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfdf_rr_scheduler_if.sv
// cfdf_rr_scheduler_if: host/actor-side signals of the round-robin scheduler.
// master = scheduler side, slave = enable/invoke/host side.
interface cfdf_rr_scheduler_if #(
  parameter int N_ACT = 4,
  parameter int CNT_W = 16
);
  localparam int PTR_W = cfdf_sched_pkg::ptr_w(N_ACT);

  logic             start;
  logic             stop;
  logic [N_ACT-1:0] enable;
  logic [N_ACT-1:0] fc;
  logic [N_ACT-1:0] invoke;
  logic [PTR_W-1:0] cur_actor;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] fire_count;
  logic             timeout_err;

  modport master (
    input  start, stop, enable, fc,
    output invoke, cur_actor, busy, done, fire_count, timeout_err
  );

  modport slave (
    output start, stop, enable, fc,
    input  invoke, cur_actor, busy, done, fire_count, timeout_err
  );
endinterface

// File: rtl/cfdf_rr_scheduler_watchdog.sv
// cfdf_sched_watchdog: firing-complete watchdog for the CFDF scheduler.
// Only elaborated when CFDF_SCHED_TIMEOUT_EN is defined.
// Down-counter loaded on clr; expire flags the (2^TMO_W-1)-th enabled cycle.
`ifdef CFDF_SCHED_TIMEOUT_EN
module cfdf_sched_watchdog #(
  parameter int TMO_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TMO_W-1:0] cnt_q;

  // Load 2^TMO_W-2 so the terminal count lands on the (2^TMO_W-1)-th wait cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= ~TMO_W'(1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TMO_W'(1);
    end
  end

  assign expire = en && (cnt_q == '0);
endmodule
`endif

// File: rtl/cfdf_rr_scheduler.sv
// cfdf_rr_scheduler: round-robin firing scheduler for N_ACT CFDF actors.
// Optional FC watchdog: define CFDF_SCHED_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | stopped, waiting for start
// CHECK     | sample enable of the actor at ptr
// INVOKE    | one-cycle invoke pulse to the actor at ptr
// WAIT_FC   | wait for fc of the actor at ptr (or watchdog expiry)
// ADVANCE   | move ptr to the next actor, honour a latched stop
// DONE      | quiescent: a full round found nothing enabled
module cfdf_rr_scheduler
  import cfdf_sched_pkg::*;
#(
  parameter int N_ACT = 4,
  parameter int CNT_W = 16,
  parameter int TMO_W = 10
) (
  input logic                 clk,
  input logic                 rst,
  cfdf_rr_scheduler_if.master bus
);
  localparam int                PTR_W     = ptr_w(N_ACT);
  localparam int                IDLE_W    = $clog2(N_ACT + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_ACT - 1);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(N_ACT);

  sched_state_e      state_q, state_nxt;
  logic [PTR_W-1:0]  ptr_q, ptr_nxt;
  logic [IDLE_W-1:0] idle_q, idle_nxt;
  logic              stop_q, stop_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              err_q, err_nxt;
  logic [N_ACT-1:0]  inv_q, inv_nxt;
  logic              busy_q, done_q;
  logic              stop_any;
  logic              wd_expire;

`ifdef CFDF_SCHED_TIMEOUT_EN
  logic wd_clr, wd_en;
  assign wd_clr = (state_q == S_INVOKE);
  assign wd_en  = (state_q == S_WAIT_FC);

  cfdf_sched_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  assign stop_any = stop_q | bus.stop;

  // Next-state, pointer, idle count, stop latch and counters.
  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    idle_nxt  = idle_q;
    stop_nxt  = stop_q;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    inv_nxt   = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt = S_CHECK;
          ptr_nxt   = '0;
          idle_nxt  = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          stop_nxt  = bus.stop;
        end
      end
      S_CHECK: begin
        stop_nxt = stop_any;
        if (stop_any) begin
          state_nxt = S_IDLE;
        end else if (bus.enable[ptr_q]) begin
          state_nxt = S_INVOKE;
          idle_nxt  = '0;
        end else begin
          idle_nxt  = idle_q + IDLE_W'(1);
          state_nxt = (idle_nxt == IDLE_FULL) ? S_DONE : S_ADVANCE;
        end
      end
      S_INVOKE: begin
        stop_nxt  = stop_any;
        state_nxt = S_WAIT_FC;
      end
      S_WAIT_FC: begin
        stop_nxt = stop_any;
        if (bus.fc[ptr_q]) begin
          if (cnt_q != '1) cnt_nxt = cnt_q + CNT_W'(1);
          state_nxt = S_ADVANCE;
        end else if (wd_expire) begin
          err_nxt   = 1'b1;
          state_nxt = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        stop_nxt  = stop_any;
        ptr_nxt   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        state_nxt = stop_any ? S_IDLE : S_CHECK;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_IDLE) stop_nxt = 1'b0;
    if (state_nxt == S_INVOKE) inv_nxt[ptr_nxt] = 1'b1;
  end

  // State and registered outputs; async reset drops any pending invoke.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idle_q  <= '0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      inv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      idle_q  <= idle_nxt;
      stop_q  <= stop_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
      inv_q   <= inv_nxt;
      busy_q  <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_q  <= (state_nxt == S_DONE);
    end
  end

  assign bus.invoke      = inv_q;
  assign bus.cur_actor   = ptr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fire_count  = cnt_q;
  assign bus.timeout_err = err_q;
endmodule

// File: doc/cfdf_rr_scheduler.md
# cfdf_rr_scheduler

Self-timed firing scheduler for N_ACT CFDF actors, such as PEA instances with their enable/invoke pairs. It replaces the hand-sequenced enable → invoke → wait(FC) loop with a synthesizable round-robin controller. It checks each actor's enable in turn and fires the enabled actor with a one-cycle invoke pulse. It waits for that actor's FC, counts completed firings, and flags quiescence when a full round finds no actor enabled. It sits between the per-actor enable modules and the invoke modules.

## Interface
- N_ACT, 4: number of scheduled actors (≥1)
- CNT_W, 16: width of firing counter
- TMO_W, 10: width of FC watchdog counter (used only with timeout feature)
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-low
- start  in  1  begin scheduling from actor 0; honoured only in IDLE or DONE
- stop  in  1  request halt after the current firing completes
- enable  in  N_ACT  per-actor enable (combinational from enable modules)
- fc  in  N_ACT  per-actor firing-complete
- invoke  out  N_ACT  one-hot one-cycle invoke pulse
- cur_actor  out  $clog2(N_ACT) (min 1)  actor index under consideration
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  quiescent: a full round found no actor enabled
- fire_count  out  CNT_W  completed firings since start, saturating
- timeout_err  out  1  sticky watchdog error (0 when feature compiled out)

## Operation
- States: IDLE, CHECK, INVOKE, WAIT_FC, ADVANCE, DONE.
- IDLE: start → CHECK, with ptr=0, idle_cnt=0 and fire_count=0.
- CHECK: sample enable[ptr].
  - If stop is high → IDLE.
  - Else if enable is high → INVOKE, idle_cnt=0.
  - Else idle_cnt++. If idle_cnt reaches N_ACT → DONE, otherwise → ADVANCE.
- INVOKE: invoke[ptr]=1 for exactly this cycle → WAIT_FC.
- WAIT_FC: stay until fc[ptr]=1, then fire_count++ (saturates at all-ones) → ADVANCE. fc of other actors is ignored.
- ADVANCE: ptr = (ptr==N_ACT-1) ? 0 : ptr+1.
  - If stop was latched → IDLE, else → CHECK.
- DONE: done=1. start → CHECK, same reset of ptr, idle_cnt and fire_count as from IDLE.
- stop is latched in any busy state and cleared on entering IDLE. stop in IDLE or DONE has no effect.
- start outside IDLE and DONE is ignored. Simultaneous start+stop in IDLE: start wins, stop is latched.
- Reset value of every output is 0. Reset mid-firing abandons the firing with no pending invoke. This applies in any state.

## Timing
- Registered outputs: invoke, done, busy, cur_actor, fire_count, timeout_err.
- Minimum firing: CHECK → INVOKE → WAIT_FC (fc already high) → ADVANCE = 4 cycles per fired actor. A skipped actor costs 2 cycles (CHECK, ADVANCE).
- start sampled in cycle t: busy=1 and cur_actor=0 at t+1. The earliest invoke[0] is at t+2.
- fc is first considered in the cycle after the invoke pulse. fc coincident with invoke is not considered.
- done asserts on the cycle after the N_ACT-th consecutive disabled CHECK.
- With N_ACT=1: ptr stays 0 and idle_cnt reaches 1 after a single disabled CHECK.

## Configuration
- CFDF_SCHED_TIMEOUT_EN defined:
  - A watchdog counts WAIT_FC cycles. It reaches all-ones (2^TMO_W-1) without fc → timeout_err=1 (sticky until start or reset), fire_count is not incremented, → ADVANCE.
- Undefined: WAIT_FC waits indefinitely and timeout_err is tied to 0.

## Structure
- Shared package cfdf_sched_pkg: state enum (6 states, 3-bit encoding) and the pointer-width function (clog2 with min 1).
- One sub-module, cfdf_sched_watchdog: cycle counter with clear/enable/expire, instantiated only under CFDF_SCHED_TIMEOUT_EN.
- The top holds the FSM, pointer, idle counter, stop latch and firing counter.

## Test plan
- N_ACT=4, enable=4'b0101, fc returned 3 cycles after each invoke, pulse start → invoke order 0,2,0,2,…; fire_count=4 after two rounds; invoke never two-hot.
- enable=0, start → done=1 exactly 8 cycles after start is sampled (4×CHECK/ADVANCE); fire_count=0; busy=0 in DONE.
- Actor 1 firing in WAIT_FC, stop pulsed → fc[1] completes it; fire_count incremented; next state IDLE; no further invoke.
- fc[2] held high while the scheduler waits on actor 1 → ignored; fire_count unchanged until fc[1].
- CFDF_SCHED_TIMEOUT_EN, TMO_W=4, fc never returned for actor 0 → timeout_err=1 after 15 WAIT_FC cycles; scheduler advances to actor 1; fire_count=0.
- rst asserted low during WAIT_FC → all outputs 0 immediately (asynchronous); after release the scheduler stays in IDLE until start.
